// File: rtl/ysyx_22040127_mem_arbiter_pkg.sv
// Shared types for the IF/LSU memory-port arbiter.
// Owner and FSM encodings plus default bus widths.
package ysyx_22040127_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22040127_mem_arbiter_if.sv
// Request/response bus between a requester and a memory-side port.
// master drives requests, slave answers them.
interface ysyx_22040127_mem_arbiter_if
  import ysyx_22040127_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  localparam int MASK_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, req_wen,
    output req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_wen,
    input  req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ysyx_22040127_mem_arbiter_pick.sv
// Combinational grant selection between IF and LSU.
// MEM_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_22040127_arb_pick
  import ysyx_22040127_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_grant,
`endif
  output logic   grant_if,
  output logic   grant_lsu
);

  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    unique case (1'b1)
      (if_valid && lsu_valid): begin
`ifdef MEM_ARB_RR_EN
        grant_lsu = (last_grant == OWN_IF);
        grant_if  = (last_grant == OWN_LSU);
`else
        grant_lsu = 1'b1;
`endif
      end
      (lsu_valid && !if_valid): grant_lsu = 1'b1;
      (if_valid && !lsu_valid): grant_if  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Shares one memory port between IF and LSU, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration.
module ysyx_22040127_mem_arbiter
  import ysyx_22040127_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
)(
  input  logic clk,
  input  logic rst,
  ysyx_22040127_mem_arbiter_if.slave  if_bus,
  ysyx_22040127_mem_arbiter_if.slave  lsu_bus,
  ysyx_22040127_mem_arbiter_if.master mem_bus,
  output logic busy
);
  localparam int MASK_W = DATA_W / 8;

  state_e            state;
  state_e            state_nx;
  owner_e            owner;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              grant_if;
  logic              grant_lsu;

`ifdef MEM_ARB_RR_EN
  owner_e last_grant;
`endif

  ysyx_22040127_arb_pick u_pick (
    .if_valid   (if_bus.req_valid),
    .lsu_valid  (lsu_bus.req_valid),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant_if   (grant_if),
    .grant_lsu  (grant_lsu)
  );

  always_comb begin
    state_nx          = state;
    if_bus.req_ready  = 1'b0;
    lsu_bus.req_ready = 1'b0;
    if_bus.rsp_valid  = 1'b0;
    lsu_bus.rsp_valid = 1'b0;
    mem_bus.req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if_bus.req_ready  = grant_if;
        lsu_bus.req_ready = grant_lsu;
        if (grant_if || grant_lsu) state_nx = REQ;
      end
      REQ: begin
        mem_bus.req_valid = 1'b1;
        if (mem_bus.req_ready) state_nx = RESP;
      end
      RESP: begin
        if (mem_bus.rsp_valid) begin
          if_bus.rsp_valid  = (owner == OWN_IF);
          lsu_bus.rsp_valid = (owner == OWN_LSU);
          state_nx          = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // The in-flight transaction is dropped silently under reset.
    if (rst) begin
      if_bus.req_ready  = 1'b0;
      lsu_bus.req_ready = 1'b0;
      if_bus.rsp_valid  = 1'b0;
      lsu_bus.rsp_valid = 1'b0;
      mem_bus.req_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_IF;
      addr  <= '0;
      wen   <= 1'b0;
      wdata <= '0;
      wmask <= '0;
    end else begin
      state <= state_nx;
      if (lsu_bus.req_ready) begin
        owner <= OWN_LSU;
        addr  <= lsu_bus.req_addr;
        wen   <= lsu_bus.req_wen;
        wdata <= lsu_bus.req_wdata;
        wmask <= lsu_bus.req_wmask;
      end else if (if_bus.req_ready) begin
        owner <= OWN_IF;
        addr  <= if_bus.req_addr;
        wen   <= 1'b0;
        wdata <= '0;
        wmask <= '0;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)                    last_grant <= OWN_IF;
    else if (lsu_bus.req_ready) last_grant <= OWN_LSU;
    else if (if_bus.req_ready)  last_grant <= OWN_IF;
  end
`endif

  assign mem_bus.req_addr  = addr;
  assign mem_bus.req_wen   = wen;
  assign mem_bus.req_wdata = wdata;
  assign mem_bus.req_wmask = wmask;
  assign if_bus.rsp_data   = mem_bus.rsp_data;
  assign lsu_bus.rsp_data  = mem_bus.rsp_data;
  assign busy              = (state != IDLE);

endmodule
